// File: rtl/sensor_flag_gen_pkg.sv
// Shared definitions for the sensor flag generator: channel codes, default
// thresholds and the switch debounce state encoding.
package sensor_pkg;

    typedef enum logic [1:0] {
        CH_TEMP = 2'd0,
        CH_CORR = 2'd1,
        CH_HUMO = 2'd2,
        CH_INV  = 2'd3
    } ch_e;

    localparam int TEMP_HI_DEF = 180;
    localparam int TEMP_LO_DEF = 170;
    localparam int CORR_HI_DEF = 200;
    localparam int CORR_LO_DEF = 190;
    localparam int HUMO_HI_DEF = 100;
    localparam int HUMO_LO_DEF = 90;

    typedef enum logic {
        DEB_STABLE   = 1'b0,
        DEB_COUNTING = 1'b1
    } deb_state_e;

endpackage

// File: rtl/sensor_flag_gen_if.sv
// Sample/switch input bundle and conditioned flag outputs of the sensor flag
// generator; the master side feeds samples, the slave side is the conditioner.
interface sensor_flag_gen_if #(
    parameter int DATA_W = 8
) ();
    logic              sw_raw;
    logic              sample_valid;
    logic [1:0]        sample_ch;
    logic [DATA_W-1:0] sample_data;
    logic              interruptor;
    logic              temp;
    logic              corriente_25;
    logic              humo;
    logic              sample_err;

    modport master (
        output sw_raw, sample_valid, sample_ch, sample_data,
        input  interruptor, temp, corriente_25, humo, sample_err
    );

    modport slave (
        input  sw_raw, sample_valid, sample_ch, sample_data,
        output interruptor, temp, corriente_25, humo, sample_err
    );
endinterface

// File: rtl/sensor_flag_gen_hyst_confirm.sv
// One analog channel: threshold compare with hysteresis and a run of
// CONFIRM_N consecutive qualifying samples before the flag toggles.
module hyst_confirm #(
    parameter int DATA_W    = 8,
    parameter int HI        = 180,
    parameter int LO        = 170,
    parameter int CONFIRM_N = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    output logic              flag
);
    localparam int CW = $clog2(CONFIRM_N + 1);
    localparam logic [DATA_W-1:0] HI_V = DATA_W'(HI);
    localparam logic [DATA_W-1:0] LO_V = DATA_W'(LO);

    if (LO >= HI) begin : g_bad_thresholds
        $error("hyst_confirm: LO threshold must be strictly below HI");
    end
    if (CONFIRM_N < 1) begin : g_bad_confirm
        $error("hyst_confirm: CONFIRM_N must be at least 1");
    end

    logic          flag_q, flag_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          qual_s;

    // Next-state: qualifying direction depends on the current flag level.
    always_comb begin
        flag_d = flag_q;
        cnt_d  = cnt_q;
        qual_s = flag_q ? (data <= LO_V) : (data >= HI_V);
        if (en) begin
            if (!qual_s) begin
                cnt_d = {CW{1'b0}};
            end else if (cnt_q == CW'(CONFIRM_N - 1)) begin
                flag_d = ~flag_q;
                cnt_d  = {CW{1'b0}};
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Flag and confirm counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q <= 1'b0;
            cnt_q  <= {CW{1'b0}};
        end else begin
            flag_q <= flag_d;
            cnt_q  <= cnt_d;
        end
    end

    assign flag = flag_q;
endmodule

// File: rtl/sensor_flag_gen.sv
// Conditions raw ADC samples and the operator switch into clean registered
// level flags for the alarm state machine.
module sensor_flag_gen
    import sensor_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEB_CYCLES = 16,
    parameter int CONFIRM_N  = 3,
    parameter int TEMP_HI    = TEMP_HI_DEF,
    parameter int TEMP_LO    = TEMP_LO_DEF,
    parameter int CORR_HI    = CORR_HI_DEF,
    parameter int CORR_LO    = CORR_LO_DEF,
    parameter int HUMO_HI    = HUMO_HI_DEF,
    parameter int HUMO_LO    = HUMO_LO_DEF
) (
    input logic              clk,
    input logic              rst,
    sensor_flag_gen_if.slave bus
);
    localparam int DCW = $clog2(DEB_CYCLES);

    if (DEB_CYCLES < 2) begin : g_bad_deb
        $error("sensor_flag_gen: DEB_CYCLES must be at least 2");
    end

    logic [1:0]     sync_q, sync_d;
    logic           sw_s;
    deb_state_e     state_q, state_d;
    logic [DCW-1:0] cnt_q, cnt_d;
    logic           intr_q, intr_d;
    logic           err_q, err_d;
    logic           en_temp_s, en_corr_s, en_humo_s;

    assign sw_s = sync_q[1];

    // Debounce next-state: a mismatch must persist DEB_CYCLES checks to toggle.
    always_comb begin
        sync_d  = {sync_q[0], bus.sw_raw};
        state_d = state_q;
        cnt_d   = cnt_q;
        intr_d  = intr_q;
        case (state_q)
            DEB_STABLE: begin
                if (sw_s != intr_q) begin
                    state_d = DEB_COUNTING;
                    cnt_d   = DCW'(1);
                end else begin
                    cnt_d = {DCW{1'b0}};
                end
            end
            DEB_COUNTING: begin
                if (sw_s == intr_q) begin
                    state_d = DEB_STABLE;
                    cnt_d   = {DCW{1'b0}};
                end else if (cnt_q == DCW'(DEB_CYCLES - 1)) begin
                    intr_d  = ~intr_q;
                    state_d = DEB_STABLE;
                    cnt_d   = {DCW{1'b0}};
                end else begin
                    cnt_d = cnt_q + DCW'(1);
                end
            end
            default: begin
                state_d = DEB_STABLE;
                cnt_d   = {DCW{1'b0}};
            end
        endcase
        err_d = bus.sample_valid && (bus.sample_ch == CH_INV);
    end

    // Synchroniser, debounce FSM and error pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b00;
            state_q <= DEB_STABLE;
            cnt_q   <= {DCW{1'b0}};
            intr_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            intr_q  <= intr_d;
            err_q   <= err_d;
        end
    end

    assign en_temp_s = bus.sample_valid && (bus.sample_ch == CH_TEMP);
    assign en_corr_s = bus.sample_valid && (bus.sample_ch == CH_CORR);
    assign en_humo_s = bus.sample_valid && (bus.sample_ch == CH_HUMO);

    hyst_confirm #(.DATA_W(DATA_W), .HI(TEMP_HI), .LO(TEMP_LO), .CONFIRM_N(CONFIRM_N)) u_temp (
        .clk (clk), .rst (rst), .en (en_temp_s), .data (bus.sample_data), .flag (bus.temp)
    );
    hyst_confirm #(.DATA_W(DATA_W), .HI(CORR_HI), .LO(CORR_LO), .CONFIRM_N(CONFIRM_N)) u_corr (
        .clk (clk), .rst (rst), .en (en_corr_s), .data (bus.sample_data), .flag (bus.corriente_25)
    );
    hyst_confirm #(.DATA_W(DATA_W), .HI(HUMO_HI), .LO(HUMO_LO), .CONFIRM_N(CONFIRM_N)) u_humo (
        .clk (clk), .rst (rst), .en (en_humo_s), .data (bus.sample_data), .flag (bus.humo)
    );

    assign bus.interruptor = intr_q;
    assign bus.sample_err  = err_q;
endmodule

// File: tb/tb_sensor_flag_gen.sv
// Directed bench for sensor_flag_gen: a behavioural reference model checked
// every cycle, plus hand-computed expectations at the interesting points.
module tb_sensor_flag_gen;
    localparam int DEB = 16;
    localparam int CN  = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    sensor_flag_gen_if #(.DATA_W(8)) bus ();

    sensor_flag_gen #(.DATA_W(8), .DEB_CYCLES(DEB), .CONFIRM_N(CN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: thresholds per channel, run lengths as plain integers.
    int   hi_t [3] = '{180, 200, 100};
    int   lo_t [3] = '{170, 190, 90};
    logic m_flag [3];
    int   m_run  [3];
    logic m_s1, m_s2, m_intr, m_err;
    int   m_deb_run;

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_flag[i] = 1'b0;
            m_run[i]  = 0;
        end
        m_s1 = 1'b0; m_s2 = 1'b0; m_intr = 1'b0; m_err = 1'b0; m_deb_run = 0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_flag[i] = 1'b0;
                m_run[i]  = 0;
            end
            m_s1 = 1'b0; m_s2 = 1'b0; m_intr = 1'b0; m_err = 1'b0; m_deb_run = 0;
        end else begin
            // switch: count consecutive checks where the synced level differs
            if (m_s2 != m_intr) begin
                m_deb_run = m_deb_run + 1;
                if (m_deb_run == DEB) begin
                    m_intr    = ~m_intr;
                    m_deb_run = 0;
                end
            end else begin
                m_deb_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = bus.sw_raw;
            m_err = bus.sample_valid && (bus.sample_ch == 2'd3);
            if (bus.sample_valid && bus.sample_ch != 2'd3) begin
                int ch;
                int v;
                bit q;
                ch = int'(bus.sample_ch);
                v  = int'(bus.sample_data);
                q  = m_flag[ch] ? (v <= lo_t[ch]) : (v >= hi_t[ch]);
                if (q) begin
                    m_run[ch] = m_run[ch] + 1;
                    if (m_run[ch] == CN) begin
                        m_flag[ch] = ~m_flag[ch];
                        m_run[ch]  = 0;
                    end
                end else begin
                    m_run[ch] = 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0b, expected %0b", nm, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("cmp_interruptor", bus.interruptor, m_intr);
        chk("cmp_temp", bus.temp, m_flag[0]);
        chk("cmp_corriente_25", bus.corriente_25, m_flag[1]);
        chk("cmp_humo", bus.humo, m_flag[2]);
        chk("cmp_sample_err", bus.sample_err, m_err);
    end

    task automatic send(input logic [1:0] ch, input logic [7:0] d);
        bus.sample_valid = 1'b1;
        bus.sample_ch    = ch;
        bus.sample_data  = d;
        @(negedge clk);
        bus.sample_valid = 1'b0;
    endtask

    initial begin
        bus.sw_raw       = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_ch    = 2'd0;
        bus.sample_data  = 8'd0;
        rst = 1'b0;
        #3 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_interruptor", bus.interruptor, 1'b0);
        chk("rst_temp", bus.temp, 1'b0);
        chk("rst_corr", bus.corriente_25, 1'b0);
        chk("rst_humo", bus.humo, 1'b0);
        chk("rst_err", bus.sample_err, 1'b0);
        #2 rst = 1'b0;
        @(negedge clk);

        // temp: three 180s assert; LO-side run broken by 175; 170 counts as below
        send(2'd0, 8'd180); chk("temp_after1", bus.temp, 1'b0);
        send(2'd0, 8'd180); chk("temp_after2", bus.temp, 1'b0);
        send(2'd0, 8'd180); chk("temp_after3", bus.temp, 1'b1);
        send(2'd0, 8'd169); send(2'd0, 8'd175); send(2'd0, 8'd169); send(2'd0, 8'd169);
        chk("temp_hold_broken_run", bus.temp, 1'b1);
        send(2'd0, 8'd170); chk("temp_fall_at_lo", bus.temp, 1'b0);

        // ignored when strobe is low
        bus.sample_ch = 2'd0; bus.sample_data = 8'd255;
        repeat (5) @(negedge clk);
        chk("temp_no_valid", bus.temp, 1'b0);

        // current: 195 clears the run; run then continues from the last 200
        send(2'd1, 8'd200); send(2'd1, 8'd200); send(2'd1, 8'd195); send(2'd1, 8'd200);
        chk("corr_after_break", bus.corriente_25, 1'b0);
        send(2'd1, 8'd200); chk("corr_run2", bus.corriente_25, 1'b0);
        send(2'd1, 8'd200); chk("corr_run3", bus.corriente_25, 1'b1);

        // smoke: interleaved temp samples do not break the run
        send(2'd2, 8'd100); send(2'd0, 8'd50); send(2'd2, 8'd100); send(2'd0, 8'd50);
        chk("humo_before_third", bus.humo, 1'b0);
        send(2'd2, 8'd100); chk("humo_after_third", bus.humo, 1'b1);

        // invalid channel
        send(2'd3, 8'd255);
        chk("err_pulse", bus.sample_err, 1'b1);
        chk("err_temp_hold", bus.temp, 1'b0);
        chk("err_corr_hold", bus.corriente_25, 1'b1);
        chk("err_humo_hold", bus.humo, 1'b1);
        @(negedge clk);
        chk("err_one_cycle", bus.sample_err, 1'b0);

        // switch: 10-clock glitch ignored, then clean edge after 18 clocks
        bus.sw_raw = 1'b1;
        repeat (10) @(negedge clk);
        bus.sw_raw = 1'b0;
        repeat (25) @(negedge clk);
        chk("sw_glitch_ignored", bus.interruptor, 1'b0);
        bus.sw_raw = 1'b1;
        repeat (17) @(negedge clk);
        chk("sw_edge_minus1", bus.interruptor, 1'b0);
        @(negedge clk);
        chk("sw_edge_18", bus.interruptor, 1'b1);
        repeat (12) @(negedge clk);
        bus.sw_raw = 1'b0;
        repeat (20) @(negedge clk);
        chk("sw_fall", bus.interruptor, 1'b0);

        // async reset mid-confirmation
        send(2'd0, 8'd180); send(2'd0, 8'd180);
        #2 rst = 1'b1;
        #1;
        chk("arst_corr", bus.corriente_25, 1'b0);
        chk("arst_humo", bus.humo, 1'b0);
        chk("arst_temp", bus.temp, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        send(2'd0, 8'd180); chk("post_rst_one", bus.temp, 1'b0);
        send(2'd0, 8'd180); chk("post_rst_two", bus.temp, 1'b0);
        send(2'd0, 8'd180); chk("post_rst_three", bus.temp, 1'b1);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
